booth_mac_accum: RTL
====================

# booth_mac_accum

Downstream consumer of the Booth multiplier. Detects each completed product (rising edge of the multiplier's `ready`), sign-extends it and accumulates it into a wide signed register. After every `BLOCK_LEN` products it presents the block sum on a valid/ready output port, then restarts accumulation. Overflow and output-overrun conditions are reported as sticky flags.

## Interface
- `OPERAND_BITS`, 8: multiplier operand width; the product is `2*OPERAND_BITS` bits.
- `ACC_BITS`, 24: accumulator and output width; must be at least `2*OPERAND_BITS`.
- `BLOCK_LEN`, 4: products per emitted sum; must be at least 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `prod_in`  in  2*OPERAND_BITS  signed product (the multiplier's `comp` result).
- `prod_rdy`  in  1  multiplier `ready` level.
- `clear`  in  1  synchronous flush of the accumulator, counter and flags.
- `acc_out`  out  ACC_BITS  signed block sum.
- `out_valid`  out  1  `acc_out` holds an unconsumed sum.
- `out_ready`  in  1  consumer accepts `acc_out`.
- `cnt`  out  $clog2(BLOCK_LEN)+1  products accumulated in the current block.
- `overflow`  out  1  sticky: signed overflow in the accumulator.
- `overrun`  out  1  sticky: a block sum was dropped.

## Operation
- Capture: `cap = prod_rdy & ~rdy_q`, where `rdy_q` is a 1-cycle delay of `prod_rdy`. `prod_in` is sampled in the cap cycle.
- A level that stays high produces one capture only.
- Addition: `acc_next = acc + sext(prod_in)`, computed at `ACC_BITS+1` bits. Signed overflow is true when the two top bits of the result differ.
- On overflow: `overflow` is set, and the wrap or saturation rule under Configuration applies.
- States: ACCUM (`cnt` below `BLOCK_LEN`) and a separate output-holding register.
- A cap that brings `cnt` to `BLOCK_LEN`:
  - loads `acc_next` into the output register and sets `out_valid`;
  - clears `acc` and `cnt` to 0.
- Overrun: if a block completes while `out_valid`=1 and `out_ready`=0, the new sum is discarded. `overrun` is set, `acc_out` keeps the old value, and `acc`/`cnt` still clear.
- Completion in the same cycle as a transfer (`out_valid & out_ready`): the new sum is loaded, `out_valid` stays 1, and `overrun` is not set.
- Transfer with no completion: `out_valid` goes to 0 on the next edge and `acc_out` holds its value.
- `clear`:
  - zeroes `acc`, `cnt`, `acc_out`, `out_valid`, `overflow` and `overrun`;
  - takes priority over a capture in the same cycle, which drops that product;
  - does not change `rdy_q`.

## Timing
- Reset values: `acc_out`=0, `out_valid`=0, `cnt`=0, `overflow`=0, `overrun`=0. Internally, `acc`=0 and `rdy_q`=1, so a `prod_rdy` already high at reset release is not captured.
- Capture latency: `acc`/`cnt` update on the edge that ends the cap cycle.
- Sum latency: `out_valid` rises 1 cycle after the cap cycle of the `BLOCK_LEN`-th product.
- Throughput: one capture every 2 cycles at most, because `prod_rdy` must go low and then high again.
- `out_valid` drops only after a handshake or a `clear`; it never drops otherwise.
- `acc_out` is stable while `out_valid`=1.
- Reset mid-block: the partial sum is lost and no output is produced.

## Configuration
- `BOOTH_MAC_SAT_EN` defined: on overflow, `acc_next` clamps to `2^(ACC_BITS-1)-1` (positive) or `-2^(ACC_BITS-1)` (negative). `overflow` is still set.
- `BOOTH_MAC_SAT_EN` undefined: the result wraps modulo `2^ACC_BITS`, and `overflow` is set.

## Structure
- Package `booth_pkg`:
  - default `OPERAND_BITS`;
  - a `prod_t` typedef at `2*OPERAND_BITS` bits;
  - a function returning the `ACC_BITS` min/max constants;
  - a sign-extension helper.
- One sub-module, `rdy_edge_det`: a rising-edge detector with a parameterised reset value for its delay register (1 here).
- Top level: accumulator, counter, output register and flags.

## Test plan
- Basic block, defaults: products 3, -5, 100, 1 on four `prod_rdy` pulses, `out_ready`=1 → one `out_valid` pulse with `acc_out`=99; `cnt` then reads 0.
- Level hold: `prod_rdy` high for 10 cycles with `prod_in`=7 → exactly one capture, `cnt`=1.
- Backpressure and overrun: `out_ready`=0 and 8 products of 1 → `acc_out`=4 held, `overrun`=1. Raising `out_ready` then gives one transfer of 4.
- Overflow, `ACC_BITS`=16, four products of 16384 (-128 × -128) → `overflow`=1. `acc_out`=0 without the macro; `acc_out`=32767 with `BOOTH_MAC_SAT_EN`.
- Clear versus capture: `clear` in the same cycle as a cap of `prod_in`=50 after 2 prior products → `cnt`=0 and `acc`=0; the next block sums only later products.
- Reset with `prod_rdy` held high: release `rst_n` → no capture until `prod_rdy` falls and rises again. All outputs read 0 after reset.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier product accumulator.
// Contents: default operand width, product type, accumulator limits, sign extension.
// Pure declarations; no state, no latency, no flow control.
package booth_pkg;

   localparam int DEF_OPERAND_BITS = 8;

   typedef logic signed [2*DEF_OPERAND_BITS-1:0] prod_t;

   // Largest (want_max=1) or smallest (want_max=0) signed value held in 'bits' bits.
   function automatic logic signed [63:0] acc_limit(input int unsigned bits, input logic want_max);
      logic signed [63:0] one;
      one = 64'sd1;
      if (want_max) return (one <<< (bits - 1)) - one;
      else          return -(one <<< (bits - 1));
   endfunction

   // Treat bit (bits-1) of v as the sign and replicate it into the upper bits.
   function automatic logic signed [63:0] sext64(input logic [63:0] v, input int unsigned bits);
      logic signed [63:0] t;
      t = $signed(v << (64 - bits));
      return t >>> (64 - bits);
   endfunction

endpackage

// File: rtl/rdy_edge_det.sv
// Rising-edge detector on a level input, delay register with parameterised reset value.
// Latency: rise is combinational from sig_in in the same cycle as the low-to-high change.
// Backpressure: none; one pulse per rising edge regardless of how long the level stays high.
// Ports: clk, rst_n (sync, active-low), sig_in level in, rise pulse out.
module rdy_edge_det #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic sig_d, sig_q;

   always_comb begin
      sig_d = sig_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sig_q <= RST_VAL;
      else        sig_q <= sig_d;
   end

   assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates Booth products (one per rising edge of prod_rdy) and emits a sum every BLOCK_LEN products.
// Latency: acc/cnt update on the edge ending the capture cycle; out_valid rises one cycle after the last capture.
// Backpressure: valid/ready output; a block completing while a sum is still held is dropped and flagged in overrun.
// Ports: clk, rst_n (sync, active-low), prod_in/prod_rdy from the multiplier, clear flush,
//        acc_out/out_valid/out_ready result port, cnt block progress, sticky overflow/overrun.
// Option: define BOOTH_MAC_SAT_EN to saturate on overflow instead of wrapping.
import booth_pkg::*;

module booth_mac_accum #(
   parameter int OPERAND_BITS = DEF_OPERAND_BITS,
   parameter int ACC_BITS     = 24,
   parameter int BLOCK_LEN    = 4,
   localparam int PROD_BITS   = 2 * OPERAND_BITS,
   localparam int CNT_W       = $clog2(BLOCK_LEN) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PROD_BITS-1:0] prod_in,
   input  logic                 prod_rdy,
   input  logic                 clear,
   output logic [ACC_BITS-1:0]  acc_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     cnt,
   output logic                 overflow,
   output logic                 overrun
);

   logic cap;

   rdy_edge_det #(.RST_VAL(1'b1)) u_rdy_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (prod_rdy),
      .rise   (cap)
   );

   logic [ACC_BITS-1:0] acc_d, acc_q;
   logic [ACC_BITS-1:0] acc_out_d, acc_out_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;
   logic                out_valid_d, out_valid_q;
   logic                overflow_d, overflow_q;
   logic                overrun_d, overrun_q;

   logic [ACC_BITS:0]   prod_ext;
   logic [ACC_BITS:0]   sum_ext;
   logic                sum_ovf;
   logic [ACC_BITS-1:0] acc_next;
   logic [CNT_W-1:0]    cnt_inc;
   logic                block_done;

   always_comb begin
      prod_ext = (ACC_BITS+1)'(sext64(64'(prod_in), PROD_BITS));
      // One guard bit: the two top bits disagree exactly when the signed sum left the ACC_BITS range.
      sum_ext  = {acc_q[ACC_BITS-1], acc_q} + prod_ext;
      sum_ovf  = sum_ext[ACC_BITS] ^ sum_ext[ACC_BITS-1];
`ifdef BOOTH_MAC_SAT_EN
      // The guard bit carries the true sign of the out-of-range result.
      if (sum_ovf) acc_next = ACC_BITS'(acc_limit(ACC_BITS, ~sum_ext[ACC_BITS]));
      else         acc_next = sum_ext[ACC_BITS-1:0];
`else
      acc_next = sum_ext[ACC_BITS-1:0];
`endif
      cnt_inc    = cnt_q + CNT_W'(1);
      block_done = (cnt_inc == CNT_W'(BLOCK_LEN));
   end

   always_comb begin
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;
      overrun_d   = overrun_q;
      if (clear) begin
         // Flush wins over a same-cycle capture; that product is lost.
         acc_d       = '0;
         acc_out_d   = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         overflow_d  = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         if (out_valid_q && out_ready) out_valid_d = 1'b0;
         if (cap) begin
            if (sum_ovf) overflow_d = 1'b1;
            if (block_done) begin
               acc_d = '0;
               cnt_d = '0;
               if (out_valid_q && !out_ready) begin
                  // Held sum not yet taken: keep it, drop the new one.
                  overrun_d = 1'b1;
               end else begin
                  acc_out_d   = acc_next;
                  out_valid_d = 1'b1;
               end
            end else begin
               acc_d = acc_next;
               cnt_d = cnt_inc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q       <= '0;
         acc_out_q   <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_out_q   <= acc_out_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         overrun_q   <= overrun_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign out_valid = out_valid_q;
   assign cnt       = cnt_q;
   assign overflow  = overflow_q;
   assign overrun   = overrun_q;

endmodule
